// File: rtl/game_countdown_timer.sv
// Round countdown timer: counts mm:ss down on each one_sec_tick while running,
// with start/restart, pause toggle and bonus-time insertion. All outputs are
// registered, so each response appears the cycle after its input is sampled.
// Optional build macro WARN_BLINK_EN: the low-time warning blinks (toggles per
// accepted tick) instead of being a steady level.
//
// Handshake: every control input (start, pause, add_bonus, one_sec_tick) is a
// single-cycle pulse sampled on the rising edge; there is no back-pressure.
// The FSM state is observable through running/paused/expired (all low = IDLE).
module game_countdown_timer #(
  parameter int INIT_MIN  = 2,
  parameter int INIT_SEC  = 0,
  parameter int BONUS_SEC = 5,
  parameter int WARN_SECS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       one_sec_tick,
  input  logic       start,
  input  logic       pause,
  input  logic       add_bonus,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       paused,
  output logic       expired,
  output logic       time_up,
  output logic       warn
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_EXP   = 2'd3;

  localparam logic [3:0] INIT_MT = 4'(INIT_MIN / 10);
  localparam logic [3:0] INIT_MO = 4'(INIT_MIN % 10);
  localparam logic [3:0] INIT_ST = 4'(INIT_SEC / 10);
  localparam logic [3:0] INIT_SO = 4'(INIT_SEC % 10);

  localparam logic [5:0] BONUS_FULL = 6'(BONUS_SEC);
  localparam logic [5:0] BONUS_NET  = 6'(BONUS_SEC - 1);
  localparam logic [5:0] WARN_LIM   = 6'(WARN_SECS);

  logic [1:0] state, state_nxt;
  logic [3:0] mt_n, mo_n, st_n, so_n;
  logic       tu_nxt, warn_nxt, win_nxt;
  logic       is_zero, is_one;
  logic [5:0] sec_bin, sec_n_bin;
  logic [5:0] add_amt, add_sec;
  logic [6:0] add_sum;
  logic       add_carry;
  logic [3:0] add_mt, add_mo, add_st, add_so;
  logic [3:0] dec_mt, dec_mo, dec_st, dec_so;

  assign sec_bin   = ({2'b00, sec_tens} * 6'd10) + {2'b00, sec_ones};
  assign sec_n_bin = ({2'b00, st_n} * 6'd10) + {2'b00, so_n};
  assign is_zero   = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                     (sec_tens == 4'd0) && (sec_ones == 4'd0);
  assign is_one    = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                     (sec_tens == 4'd0) && (sec_ones == 4'd1);

  // Bonus addition: seconds carry into minutes, clamped at 99:59. A tick in
  // the same RUN cycle is folded in by adding one second less.
  always_comb begin
    add_amt   = (state == S_RUN && one_sec_tick) ? BONUS_NET : BONUS_FULL;
    add_sum   = {1'b0, sec_bin} + {1'b0, add_amt};
    add_carry = (add_sum >= 7'd60);
    add_sec   = add_carry ? 6'(add_sum - 7'd60) : add_sum[5:0];
    add_st    = 4'd0;
    if      (add_sec >= 6'd50) add_st = 4'd5;
    else if (add_sec >= 6'd40) add_st = 4'd4;
    else if (add_sec >= 6'd30) add_st = 4'd3;
    else if (add_sec >= 6'd20) add_st = 4'd2;
    else if (add_sec >= 6'd10) add_st = 4'd1;
    add_so = 4'(add_sec - ({2'b00, add_st} * 6'd10));
    add_mt = min_tens;
    add_mo = min_ones;
    if (add_carry) begin
      if (min_ones != 4'd9) begin
        add_mo = min_ones + 4'd1;
      end else if (min_tens != 4'd9) begin
        add_mo = 4'd0;
        add_mt = min_tens + 4'd1;
      end else begin
        add_st = 4'd5;
        add_so = 4'd9;
      end
    end
  end

  // One-second BCD decrement with borrow; only used when time is non-zero.
  always_comb begin
    dec_mt = min_tens;
    dec_mo = min_ones;
    dec_st = sec_tens;
    dec_so = sec_ones;
    if (sec_ones != 4'd0) begin
      dec_so = sec_ones - 4'd1;
    end else begin
      dec_so = 4'd9;
      if (sec_tens != 4'd0) begin
        dec_st = sec_tens - 4'd1;
      end else begin
        dec_st = 4'd5;
        if (min_ones != 4'd0) begin
          dec_mo = min_ones - 4'd1;
        end else begin
          dec_mo = 4'd9;
          dec_mt = min_tens - 4'd1;
        end
      end
    end
  end

  // Next state and digits; start beats pause, pause beats bonus/tick.
  always_comb begin
    state_nxt = state;
    mt_n      = min_tens;
    mo_n      = min_ones;
    st_n      = sec_tens;
    so_n      = sec_ones;
    tu_nxt    = 1'b0;
    if (start) begin
      state_nxt = S_RUN;
      mt_n = INIT_MT; mo_n = INIT_MO; st_n = INIT_ST; so_n = INIT_SO;
    end else begin
      case (state)
        S_RUN: begin
          if (pause) begin
            state_nxt = S_PAUSE;
          end else if (add_bonus) begin
            mt_n = add_mt; mo_n = add_mo; st_n = add_st; so_n = add_so;
          end else if (is_zero) begin
            state_nxt = S_EXP;
            tu_nxt    = 1'b1;
          end else if (one_sec_tick) begin
            mt_n = dec_mt; mo_n = dec_mo; st_n = dec_st; so_n = dec_so;
            if (is_one) begin
              state_nxt = S_EXP;
              tu_nxt    = 1'b1;
            end
          end
        end
        S_PAUSE: begin
          if (pause) begin
            state_nxt = S_RUN;
          end else if (add_bonus) begin
            mt_n = add_mt; mo_n = add_mo; st_n = add_st; so_n = add_so;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Low-time window: 1..WARN_SECS seconds left while RUN or PAUSE.
  assign win_nxt = ((state_nxt == S_RUN) || (state_nxt == S_PAUSE)) &&
                   (mt_n == 4'd0) && (mo_n == 4'd0) &&
                   (sec_n_bin != 6'd0) && (sec_n_bin <= WARN_LIM);

`ifdef WARN_BLINK_EN
  logic in_win;
  logic tick_dec;

  assign tick_dec = (state == S_RUN) && !start && !pause && !add_bonus &&
                    one_sec_tick && !is_zero;

  // Blinking warning: set on window entry, toggled per decrementing tick.
  always_comb begin
    warn_nxt = 1'b0;
    if (win_nxt) begin
      if (!in_win || start) warn_nxt = 1'b1;
      else if (tick_dec)    warn_nxt = !warn;
      else                  warn_nxt = warn;
    end
  end

  // Remember whether the previous cycle was already inside the window.
  always_ff @(posedge clk) begin
    if (rst) in_win <= 1'b0;
    else     in_win <= win_nxt;
  end
`else
  assign warn_nxt = win_nxt;
`endif

  // Register state, digits and all status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      min_tens <= INIT_MT;
      min_ones <= INIT_MO;
      sec_tens <= INIT_ST;
      sec_ones <= INIT_SO;
      running  <= 1'b0;
      paused   <= 1'b0;
      expired  <= 1'b0;
      time_up  <= 1'b0;
      warn     <= 1'b0;
    end else begin
      state    <= state_nxt;
      min_tens <= mt_n;
      min_ones <= mo_n;
      sec_tens <= st_n;
      sec_ones <= so_n;
      running  <= (state_nxt == S_RUN);
      paused   <= (state_nxt == S_PAUSE);
      expired  <= (state_nxt == S_EXP);
      time_up  <= tu_nxt;
      warn     <= warn_nxt;
    end
  end

endmodule
